// File: rtl/serial_tx_drain_pkg.sv
// Shared types and helpers for the serial TX drain: FSM state encoding,
// line idle level, and the frame-length formula.
package serial_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  localparam logic IDLE_LEVEL = 1'b1;

  function automatic int frame_cycles(input int cpb, input int dw, input int sb, input bit parity);
    return (1 + dw + sb + (parity ? 1 : 0)) * cpb;
  endfunction

endpackage

// File: rtl/serial_tx_drain_baud_tick.sv
// Bit-period timer: free-running counter with a one-cycle tick on the last
// cycle of each bit period; start_i realigns it to a fresh bit period.
module serial_baud_tick
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic tick_o
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (start_i || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/serial_tx_drain.sv
// Pops bytes from a depth-1 FIFO and sends them as UART frames on TX.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bits.
module serial_tx_drain
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EMPTY_N,
  input  logic [DATA_WIDTH-1:0] D_IN,
  output logic                  DEQ,
  input  logic                  CLR,
  output logic                  TX,
  output logic                  BUSY
);

  localparam int            BW        = $clog2(DATA_WIDTH > STOP_BITS ? DATA_WIDTH : STOP_BITS);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic                    tx_q, tx_d;
  logic                    tick;

`ifdef SERIAL_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
  logic par_q;
  always_ff @(posedge CLK) begin
    if (RST)      par_q <= 1'b0;
    else if (DEQ) par_q <= ^D_IN;
  end
`else
  localparam bit PARITY_EN = 1'b0;
  logic par_q;
  assign par_q = 1'b0;
`endif

  assign DEQ  = (state_q == IDLE) && EMPTY_N && !RST && !CLR;
  assign BUSY = (state_q != IDLE);
  assign TX   = tx_q;

  serial_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_i   (CLK),
    .rst_i   (RST),
    .start_i (DEQ),
    .tick_o  (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: if (DEQ) begin
        shift_d = D_IN;
        state_d = START;
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        if (bit_q == LAST_BIT) begin
          bit_d   = '0;
          state_d = PARITY_EN ? PARITY : STOP;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      PARITY: if (tick) state_d = STOP;
      STOP: if (tick) begin
        // bit counter doubles as the stop-period counter
        if (bit_q == LAST_STOP) begin
          bit_d   = '0;
          state_d = IDLE;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (CLR) begin
      state_d = IDLE;
      bit_d   = '0;
    end
  end

  // TX is registered from next-state so the line changes on the state edge.
  always_comb begin
    tx_d = IDLE_LEVEL;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_q;
      default: tx_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

`ifndef SYNTHESIS
  logic [31:0] busy_cnt_q;
  always_ff @(posedge CLK) begin
    if (RST || state_q == IDLE) busy_cnt_q <= '0;
    else                        busy_cnt_q <= busy_cnt_q + 32'd1;
    if (!RST && !CLR && state_q == STOP && state_d == IDLE)
      assert (busy_cnt_q == 32'(frame_cycles(CLKS_PER_BIT, DATA_WIDTH, STOP_BITS, PARITY_EN) - 1))
        else $error("serial_tx_drain: frame length %0d", busy_cnt_q + 32'd1);
    if (!RST && state_q == IDLE)
      assert (!$isunknown(EMPTY_N)) else $warning("serial_tx_drain: EMPTY_N unknown in IDLE");
  end
`endif

endmodule

// File: tb/tb_serial_tx_drain.sv
// Directed bench for serial_tx_drain at CLKS_PER_BIT=4; inputs change and
// outputs are sampled just after the falling edge.
module tb_serial_tx_drain;

  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FLEN = PAR ? 44 : 40;

  logic       CLK = 1'b0;
  logic       RST, EMPTY_N, CLR;
  logic [7:0] D_IN;
  logic       DEQ, TX, BUSY;

  int vecs = 0;
  int errs = 0;

  always #5 CLK = ~CLK;

  serial_tx_drain #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .STOP_BITS(1)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .EMPTY_N (EMPTY_N),
    .D_IN    (D_IN),
    .DEQ     (DEQ),
    .CLR     (CLR),
    .TX      (TX),
    .BUSY    (BUSY)
  );

  // line level during bit period k of a frame carrying b
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR && k == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic run_frame(input string nm, input logic [7:0] b, input int ncyc,
                           input logic nxt_en, input logic [7:0] nxt_din, input bit tail);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge CLK);
      if (i == 0) begin EMPTY_N = nxt_en; D_IN = nxt_din; end
      #1;
      vecs++;
      if (TX !== exp_bit(b, i / CPB)) begin
        errs++;
        $display("FAIL %s tx cyc %0d: got %b want %b", nm, i, TX, exp_bit(b, i / CPB));
      end
      vecs++;
      if (BUSY !== 1'b1 || DEQ !== 1'b0) begin
        errs++;
        $display("FAIL %s busy/deq cyc %0d: got %b/%b want 1/0", nm, i, BUSY, DEQ);
      end
    end
    if (tail) begin
      @(negedge CLK); #1;
      vecs++;
      if (BUSY !== 1'b0 || TX !== 1'b1 || DEQ !== nxt_en) begin
        errs++;
        $display("FAIL %s end: busy/tx/deq got %b/%b/%b want 0/1/%b", nm, BUSY, TX, DEQ, nxt_en);
      end
    end
  endtask

  task automatic start_byte(input string nm, input logic [7:0] b);
    @(negedge CLK);
    EMPTY_N = 1'b1; D_IN = b;
    #1;
    vecs++;
    if (DEQ !== 1'b1 || TX !== 1'b1 || BUSY !== 1'b0) begin
      errs++;
      $display("FAIL %s deq: deq/tx/busy got %b/%b/%b want 1/1/0", nm, DEQ, TX, BUSY);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; CLR = 1'b0; EMPTY_N = 1'b1; D_IN = 8'h5A;
    @(negedge CLK); #1;
    vecs++;
    if (TX !== 1'b1 || BUSY !== 1'b0 || DEQ !== 1'b0) begin
      errs++;
      $display("FAIL reset: tx/busy/deq got %b/%b/%b want 1/0/0", TX, BUSY, DEQ);
    end
    RST = 1'b0; EMPTY_N = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK); #1;
      vecs++;
      if (TX !== 1'b1 || BUSY !== 1'b0 || DEQ !== 1'b0) begin
        errs++;
        $display("FAIL idle cyc %0d: tx/busy/deq got %b/%b/%b want 1/0/0", i, TX, BUSY, DEQ);
      end
    end
  endtask

  task automatic test_frame();
    start_byte("a5", 8'hA5);
    run_frame("a5", 8'hA5, FLEN, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_back_to_back();
    start_byte("b2b0", 8'h00);
    run_frame("b2b0", 8'h00, FLEN, 1'b1, 8'hFF, 1'b1);
    run_frame("b2b1", 8'hFF, FLEN, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_clr();
    @(negedge CLK);
    CLR = 1'b1; EMPTY_N = 1'b1; D_IN = 8'h55;
    #1;
    vecs++;
    if (DEQ !== 1'b0) begin errs++; $display("FAIL clr_idle deq: got %b want 0", DEQ); end
    @(negedge CLK);
    CLR = 1'b0;
    #1;
    vecs++;
    if (DEQ !== 1'b1) begin errs++; $display("FAIL clr_release deq: got %b want 1", DEQ); end
    run_frame("clr", 8'h55, 10, 1'b0, 8'h00, 1'b0);
    @(negedge CLK);
    CLR = 1'b1;
    #1;
    vecs++;
    if (BUSY !== 1'b1 || DEQ !== 1'b0) begin
      errs++; $display("FAIL clr_mid: busy/deq got %b/%b want 1/0", BUSY, DEQ);
    end
    @(negedge CLK);
    CLR = 1'b0; EMPTY_N = 1'b1; D_IN = 8'h3C;
    #1;
    vecs++;
    if (TX !== 1'b1 || BUSY !== 1'b0 || DEQ !== 1'b1) begin
      errs++; $display("FAIL clr_after: tx/busy/deq got %b/%b/%b want 1/0/1", TX, BUSY, DEQ);
    end
    run_frame("clr_next", 8'h3C, FLEN, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_rst_mid();
    start_byte("rst", 8'hC3);
    run_frame("rst", 8'hC3, 12, 1'b0, 8'h00, 1'b0);
    @(negedge CLK);
    RST = 1'b1; EMPTY_N = 1'b1; D_IN = 8'h96;
    #1;
    vecs++;
    if (DEQ !== 1'b0) begin errs++; $display("FAIL rst_mid deq: got %b want 0", DEQ); end
    @(negedge CLK); #1;
    vecs++;
    if (TX !== 1'b1 || BUSY !== 1'b0 || DEQ !== 1'b0) begin
      errs++; $display("FAIL rst_after: tx/busy/deq got %b/%b/%b want 1/0/0", TX, BUSY, DEQ);
    end
    RST = 1'b0;
    #1;
    vecs++;
    if (DEQ !== 1'b1) begin errs++; $display("FAIL rst_release deq: got %b want 1", DEQ); end
    run_frame("rst_next", 8'h96, FLEN, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_parity();
    start_byte("p07", 8'h07);
    run_frame("p07", 8'h07, FLEN, 1'b0, 8'h00, 1'b1);
    start_byte("p03", 8'h03);
    run_frame("p03", 8'h03, FLEN, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_clr();
    test_rst_mid();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
